muldiv_unit: RTL



---
 rtl/muldiv_pkg.sv | 49 ++++
 rtl/muldiv_div_core.sv | 72 +++++++
 rtl/muldiv_unit.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and op-decode helpers for the multiply/divide unit.
//   muldiv_op_t : 3-bit op encoding (RV32M funct3 order), fully decoded
//   state_t     : unit FSM states IDLE / BUSY / DONE
//   req_t       : op and final-negate flag latched at accept
//   is_signed_a / is_signed_b : operand is treated as two's complement
//   is_div      : op uses the divider
//   want_high   : MULH* select the high product word; REM* select the remainder
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        muldiv_op_t op;
        logic       neg;   // negate the unsigned result at completion
    } req_t;

    // MUL is handled as unsigned: its low word is sign-agnostic.
    function automatic logic is_signed_a(input muldiv_op_t op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_signed_b(input muldiv_op_t op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_div(input muldiv_op_t op);
        return op[2];
    endfunction

    function automatic logic want_high(input muldiv_op_t op);
        return op[2] ? op[1] : (op[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// div_core: restoring divider, one quotient bit per cycle, with the shared
// iteration counter used by the whole unit.
//   clk, rst      : clock, async active-high reset
//   flush         : abandon the running operation
//   start         : load dividend/divisor and begin iterating
//   dividend      : unsigned dividend
//   divisor       : unsigned divisor
//   done          : high during the last iteration cycle (combinational)
//   quo_nxt       : quotient after the current step
//   rem_nxt       : remainder after the current step
module div_core
#(
    parameter int DATA_WIDTH = 32
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] quo_nxt,
    output logic [DATA_WIDTH-1:0] rem_nxt
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    logic          running;
    logic [CW-1:0] cnt;
    logic [W-1:0]  quo, rem, dvs;
    logic [W:0]    tmp, diff;
    logic          ge;

    // Shift the next dividend bit into the partial remainder and try a subtract.
    assign tmp     = {rem, quo[W-1]};
    assign diff    = tmp - {1'b0, dvs};
    assign ge      = ~diff[W];
    assign rem_nxt = ge ? diff[W-1:0] : tmp[W-1:0];
    assign quo_nxt = {quo[W-2:0], ge};
    assign done    = running && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running <= 1'b0;
            cnt     <= '0;
            quo     <= '0;
            rem     <= '0;
            dvs     <= '0;
        end else if (flush) begin
            running <= 1'b0;
            cnt     <= '0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= '0;
            quo     <= dividend;
            rem     <= '0;
            dvs     <= divisor;
        end else if (running) begin
            quo <= quo_nxt;
            rem <= rem_nxt;
            if (done) begin
                running <= 1'b0;
                cnt     <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the execute stage.
// One op per valid/ready handshake; result held until out_ready.
//   clk, rst   : clock, async active-high reset
//   flush      : abort any in-flight op; blocks acceptance this cycle
//   in_valid   : op/src_a/src_b valid       in_ready : unit idle, can accept
//   op         : muldiv_op_t                src_a/src_b : rs1/rs2 operands
//   out_valid  : result valid               out_ready : consumer takes result
//   result     : product word / quotient / remainder
// Build option: MULDIV_FAST_MUL_EN defined -> multiplies use a combinational
// multiplier and complete one edge after accept; divides stay iterative.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  muldiv_op_t            op,
    input  logic [DATA_WIDTH-1:0] src_a,
    input  logic [DATA_WIDTH-1:0] src_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result
);
    localparam int W = DATA_WIDTH;
    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

    state_t         state;
    req_t           req_q;
    logic [2*W-1:0] acc, acc_nxt, prod;
    logic [W-1:0]   mcand;

    logic           a_neg, b_neg;
    logic [W-1:0]   a_abs, b_abs;
    logic           accept, div_zero, div_ovf, fast_hit, start;
    logic [W-1:0]   fast_res;
    logic [W:0]     sum;
    logic           div_done;
    logic [W-1:0]   quo_nxt, rem_nxt, div_val, fix_res;

    // Magnitudes at accept; MIN maps to its own bit pattern, which is the
    // correct unsigned magnitude.
    assign a_neg  = is_signed_a(op) & src_a[W-1];
    assign b_neg  = is_signed_b(op) & src_b[W-1];
    assign a_abs  = a_neg ? -src_a : src_a;
    assign b_abs  = b_neg ? -src_b : src_b;

    assign accept   = in_valid & in_ready & ~flush;
    assign div_zero = is_div(op) && (src_b == '0);
    assign div_ovf  = is_div(op) && is_signed_b(op) && (src_a == MIN_VAL) && (src_b == '1);

`ifdef MULDIV_FAST_MUL_EN
    logic [2*W-1:0] a_ext, b_ext, fprod;
    // Low 2W bits of the product of sign-extended operands are exact.
    assign a_ext    = {{W{a_neg}}, src_a};
    assign b_ext    = {{W{b_neg}}, src_b};
    assign fprod    = a_ext * b_ext;
    assign fast_hit = ~is_div(op);
    assign fast_res = want_high(op) ? fprod[2*W-1:W] : fprod[W-1:0];
`else
    assign fast_hit = 1'b0;
    assign fast_res = '0;
`endif

    assign start = (state == IDLE) & accept & ~div_zero & ~div_ovf & ~fast_hit;

    // Shift-add step: conditionally add multiplicand to the high half, then
    // shift the whole accumulator right; multiplier bits drain out the bottom.
    assign sum     = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, mcand} : '0);
    assign acc_nxt = {sum, acc[W-1:1]};
    assign prod    = req_q.neg ? -acc_nxt : acc_nxt;

    assign div_val = want_high(req_q.op) ? rem_nxt : quo_nxt;
    assign fix_res = is_div(req_q.op) ? (req_q.neg ? -div_val : div_val)
                                      : (want_high(req_q.op) ? prod[2*W-1:W] : prod[W-1:0]);

    // The divider also owns the iteration counter, so it runs for every
    // iterative op and its done pulse ends multiplies too.
    div_core #(.DATA_WIDTH(W)) u_div (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .start    (start),
        .dividend (a_abs),
        .divisor  (b_abs),
        .done     (div_done),
        .quo_nxt  (quo_nxt),
        .rem_nxt  (rem_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            req_q     <= '{op: OP_MUL, neg: 1'b0};
            acc       <= '0;
            mcand     <= '0;
        end else if (flush) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    in_ready  <= 1'b0;
                    req_q.op  <= op;
                    // Remainder takes the dividend's sign; everything else the xor.
                    req_q.neg <= (is_div(op) && want_high(op)) ? a_neg : (a_neg ^ b_neg);
                    acc       <= {{W{1'b0}}, b_abs};
                    mcand     <= a_abs;
                    if (div_zero) begin
                        result    <= want_high(op) ? src_a : '1;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (div_ovf) begin
                        result    <= want_high(op) ? '0 : MIN_VAL;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (fast_hit) begin
                        result    <= fast_res;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    acc <= acc_nxt;
                    if (div_done) begin
                        result    <= fix_res;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
